uart_rx: RTL and testbench

// - Serial receiver for the UART link: recovers 7-bit characters from the serial line and hands each one out with a single-cycle valid strobe.
// - Frame: 1 start bit (0), DATA_BITS data bits LSB-first, optional parity bit, 1 stop bit (1).
// - Sits between the board RX pin and the character consumer, such as a command decoder or display logic.
// - Samples each bit at mid-bit; CLKS_PER_BIT=1 is not supported, so a baud prescaler is built in.

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_rx_sync.sv | 13 +
 rtl/uart_rx.sv | 103 ++++++++++
 tb/tb_uart_rx.sv | 131 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and frame levels shared by the UART receiver and transmitter
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL = 1'b1;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous serial line, resets to idle-high
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);
  logic meta;
  // shift the raw line through two flops so downstream logic sees a settled level
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) {o_q, meta} <= 2'b11;
    else {o_q, meta} <= {meta, i_d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: mid-bit sampling UART receiver with optional parity and break handling
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS = 7,
  parameter int PARITY_EN = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] MID = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_IDX = 4'(DATA_BITS - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] idx, idx_n;
  logic [DATA_BITS-1:0] shreg;
  logic par_err, samp, rx_s;
  uart_rx_sync u_sync (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_rx), .o_q(rx_s));
  assign o_busy = state != IDLE;
  // next state, baud counter and bit index; samp marks a mid-bit sample point
  always_comb begin
    state_n = state;
    cnt_n = cnt + CW'(1);
    idx_n = idx;
    samp = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (rx_s == START_LVL) state_n = START;
      end
      START: if (cnt == MID) begin
        cnt_n = '0;
        idx_n = '0;
        state_n = rx_s == START_LVL ? DATA : IDLE;
      end
      DATA: if (cnt == LAST) begin
        cnt_n = '0;
        samp = 1'b1;
        idx_n = idx + 4'd1;
        if (idx == LAST_IDX) state_n = PARITY_EN != 0 ? PARITY : STOP;
      end
      PARITY: if (cnt == LAST) begin
        cnt_n = '0;
        samp = 1'b1;
        state_n = STOP;
      end
      STOP: if (cnt == LAST) begin
        cnt_n = '0;
        samp = 1'b1;
        state_n = rx_s == STOP_LVL ? IDLE : BREAK;
      end
      BREAK: begin
        cnt_n = '0;
        if (rx_s == STOP_LVL) state_n = IDLE;
      end
      default: begin
        cnt_n = '0;
        state_n = IDLE;
      end
    endcase
  end
  // FSM state, baud counter and bit index registers
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
    end
  // shift data in LSB-first, latch parity mismatch, publish the frame on the stop sample
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      shreg <= '0;
      par_err <= 1'b0;
      o_data <= '0;
      o_valid <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (samp && state == DATA) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      if (samp && state == PARITY) par_err <= rx_s != (^shreg ^ 1'(PARITY_ODD));
      if (samp && state == STOP) begin
        o_valid <= 1'b1;
        o_data <= shreg;
        o_frame_err <= rx_s != STOP_LVL;
        o_parity_err <= par_err;
      end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random frames checked against a frame-level reference model
module tb_uart_rx;
  localparam int CPB = 4;
  localparam int DB = 7;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_rx = 1'b1;
  logic [DB-1:0] o_data;
  logic o_valid, o_parity_err, o_frame_err, o_busy;
  int checks = 0;
  int errors = 0;
  logic [DB+1:0] got[$];
  logic [DB+1:0] exp_q[$];
  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_EN(1), .PARITY_ODD(0)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rx(i_rx), .o_data(o_data), .o_valid(o_valid),
    .o_parity_err(o_parity_err), .o_frame_err(o_frame_err), .o_busy(o_busy)
  );
  always #5 i_clk = ~i_clk;
  // record every strobe as {data, parity_err, frame_err}
  always @(negedge i_clk) if (o_valid) got.push_back({o_data, o_parity_err, o_frame_err});
  task automatic tick(int n);
    repeat (n) @(negedge i_clk);
  endtask
  task automatic settle(int n);
    tick(n);
    #1;
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive_bit(logic b);
    i_rx = b;
    tick(CPB);
  endtask
  // even parity: the correct parity bit equals the XOR of the data bits
  task automatic send(logic [DB-1:0] d, logic pbit, logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    drive_bit(pbit);
    drive_bit(stop);
    exp_q.push_back({d, pbit != (^d), ~stop});
  endtask
  task automatic check_frames(string tag);
    logic [DB+1:0] g, e;
    chk({tag, "_count"}, got.size(), exp_q.size());
    while (got.size() > 0 && exp_q.size() > 0) begin
      g = got.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_data"}, 32'(g[DB+1:2]), 32'(e[DB+1:2]));
      chk({tag, "_perr"}, 32'(g[1]), 32'(e[1]));
      chk({tag, "_ferr"}, 32'(g[0]), 32'(e[0]));
    end
    got.delete();
    exp_q.delete();
  endtask
  task automatic check_reset_outputs(string tag);
    chk({tag, "_data"}, 32'(o_data), 0);
    chk({tag, "_valid"}, 32'(o_valid), 0);
    chk({tag, "_perr"}, 32'(o_parity_err), 0);
    chk({tag, "_ferr"}, 32'(o_frame_err), 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
  endtask
  initial begin
    logic [DB-1:0] d;
    logic bad;
    settle(3);
    check_reset_outputs("reset");
    i_rst = 1'b0;
    tick(4);
    send(7'h55, ^7'h55, 1'b1);
    settle(4);
    check_frames("single");
    chk("single_busy", 32'(o_busy), 0);
    send(7'h41, ^7'h41, 1'b1);
    send(7'h3A, ^7'h3A, 1'b1);
    settle(4);
    check_frames("b2b");
    i_rx = 1'b0;
    tick(1);
    i_rx = 1'b1;
    settle(2);
    chk("glitch_busy_high", 32'(o_busy), 1);
    settle(3);
    chk("glitch_busy_low", 32'(o_busy), 0);
    settle(CPB * 4);
    check_frames("glitch");
    send(7'h01, 1'b0, 1'b1);
    settle(4);
    check_frames("parity");
    send(7'h7F, ^7'h7F, 1'b0);
    settle(100);
    chk("break_busy", 32'(o_busy), 1);
    check_frames("break");
    i_rx = 1'b1;
    settle(4);
    chk("break_exit_busy", 32'(o_busy), 0);
    send(7'h12, ^7'h12, 1'b1);
    settle(4);
    check_frames("after_break");
    d = 7'h2C;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    i_rx = d[3];
    tick(2);
    i_rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    tick(2);
    i_rst = 1'b0;
    i_rx = 1'b1;
    settle(CPB * 12);
    chk("midreset_nostrobe", got.size(), 0);
    send(7'h2C, ^7'h2C, 1'b1);
    settle(4);
    check_frames("post_reset");
    for (int n = 0; n < 8; n++) begin
      d = DB'($urandom);
      bad = $urandom_range(0, 3) == 0;
      send(d, (^d) ^ bad, 1'b1);
      tick($urandom_range(0, 2) * CPB);
      settle(4);
      check_frames("random");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
